// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH       = 4,
  parameter int OPW         = 3,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_s,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  logic [1:0]    state;
  logic          rr;
  logic [CW-1:0] cnt;
  logic          cur_id;
  logic          grant;
  logic          take;

  // rr names the requester preferred when both are valid
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = rr;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant;
  assign take       = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr        <= 1'b0;
      cnt       <= '0;
      cur_id    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            alu_a  <= grant ? req1_a  : req0_a;
            alu_b  <= grant ? req1_b  : req0_b;
            alu_s  <= grant ? req1_op : req0_op;
            cur_id <= grant;
            cnt    <= CNT_LOAD;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_y     <= alu_y;
            rsp_carry <= alu_carry;
            rsp_zero  <= alu_zero;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr        <= ~rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a stub ALU
module tb_alu_arbiter;
  localparam int W = 4;
  localparam int O = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [O-1:0] req0_op = 0, req1_op = 0;
  logic         rsp_valid, rsp_id, rsp_carry, rsp_zero, busy;
  logic [W-1:0] rsp_y, alu_a, alu_b, alu_y;
  logic [O-1:0] alu_s;
  logic         alu_carry, alu_zero;

  logic         h_req0_valid = 0, h_rsp_ready = 1;
  logic         h_req0_ready, h_req1_ready;
  logic [W-1:0] h_req0_a = 0, h_req0_b = 0;
  logic [O-1:0] h_req0_op = 0;
  logic         h_rsp_valid, h_rsp_id, h_rsp_carry, h_rsp_zero, h_busy;
  logic [W-1:0] h_rsp_y, h_alu_a, h_alu_b, h_alu_y;
  logic [O-1:0] h_alu_s;
  logic         h_alu_carry, h_alu_zero;

  function automatic logic [W:0] stub(input logic [W-1:0] a, input logic [W-1:0] b, input logic [O-1:0] s);
    case (s)
      3'b000:  stub = {1'b0, a} + {1'b0, b};
      3'b001:  stub = {1'b0, a & b};
      3'b010:  stub = {1'b0, a | b};
      3'b011:  stub = {1'b0, a ^ b};
      default: stub = '0;
    endcase
  endfunction

  always_comb begin
    {alu_carry, alu_y}     = stub(alu_a, alu_b, alu_s);
    alu_zero               = (alu_y == '0);
    {h_alu_carry, h_alu_y} = stub(h_alu_a, h_alu_b, h_alu_s);
    h_alu_zero             = (h_alu_y == '0);
  end

  alu_arbiter #(.WIDTH(W), .OPW(O), .HOLD_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero), .busy(busy)
  );

  alu_arbiter #(.WIDTH(W), .OPW(O), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(h_req0_valid), .req0_ready(h_req0_ready), .req0_a(h_req0_a), .req0_b(h_req0_b), .req0_op(h_req0_op),
    .req1_valid(1'b0), .req1_ready(h_req1_ready), .req1_a(4'b0000), .req1_b(4'b0000), .req1_op(3'b000),
    .rsp_valid(h_rsp_valid), .rsp_ready(h_rsp_ready), .rsp_id(h_rsp_id), .rsp_y(h_rsp_y),
    .rsp_carry(h_rsp_carry), .rsp_zero(h_rsp_zero),
    .alu_a(h_alu_a), .alu_b(h_alu_b), .alu_s(h_alu_s),
    .alu_y(h_alu_y), .alu_carry(h_alu_carry), .alu_zero(h_alu_zero), .busy(h_busy)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed { logic id; logic [W-1:0] y; logic c; logic z; } rsp_t;
  rsp_t sb[$];
  rsp_t sb_e;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) check("rsp_unexpected", 32'(1), 32'(0));
      else begin
        sb_e = sb.pop_front();
        check("rsp", 32'({rsp_id, rsp_y, rsp_carry, rsp_zero}), 32'(sb_e));
      end
    end
  end

  typedef struct { logic sel; logic [W-1:0] a; logic [W-1:0] b; logic [O-1:0] op;
                   logic [W-1:0] y; logic c; logic z; } vec_t;
  vec_t vecs[10];

  task automatic drive(input logic sel, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [O-1:0] op);
    if (!sel) begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
    else      begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_one(input vec_t v);
    drive(v.sel, 1'b1, v.a, v.b, v.op);
    @(negedge clk);
    check("ready_granted", 32'(v.sel ? req1_ready : req0_ready), 32'(1));
    check("ready_other",   32'(v.sel ? req0_ready : req1_ready), 32'(0));
    sb.push_back(rsp_t'{v.sel, v.y, v.c, v.z});
    @(posedge clk); #1;
    drive(v.sel, 1'b0, v.a, v.b, v.op);
    @(negedge clk);
    check("lat_early", 32'(rsp_valid), 32'(0));
    check("exec_busy", 32'(busy), 32'(1));
    check("alu_ops", 32'({alu_a, alu_b, alu_s}), 32'({v.a, v.b, v.op}));
    @(negedge clk);
    check("lat_rsp", 32'(rsp_valid), 32'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin @(negedge clk); #1; t++; end
    check("drain", 32'(sb.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    @(negedge clk);
    while (!(req0_ready || req1_ready) && t < 10) begin @(negedge clk); t++; end
    if (t >= 10) check(name, 32'(0), 32'(1));
  endtask

  task automatic check_reset_outputs();
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_y, rsp_carry, rsp_zero}), 32'(0));
    check("rst_alu", 32'({alu_a, alu_b, alu_s}), 32'(0));
    check("rst_ready_busy", 32'({req0_ready, req1_ready, busy}), 32'(0));
  endtask

  logic [6:0] snap;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 4'b1010, 4'b0101, 3'b000, 4'b1111, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'b1000, 4'b1000, 3'b000, 4'b0000, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 4'b1010, 4'b0101, 3'b001, 4'b0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 4'b0111, 4'b0011, 3'b000, 4'b1010, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'b1100, 4'b1010, 3'b001, 4'b1000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 4'b1100, 4'b1010, 3'b010, 4'b1110, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'b1100, 4'b1010, 3'b011, 4'b0110, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 4'b0101, 4'b0101, 3'b011, 4'b0000, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 4'b1111, 4'b1111, 3'b000, 4'b1110, 1'b1, 1'b0};

    // Reset holds everything low, even with a requester valid
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); check("idle_stays", 32'(busy), 32'(0)); end
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_one(vecs[i]);
    drain();

    // Both valid after reset: req0 first, then strict alternation
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 4'b1000, 4'b1000, 3'b000);
    drive(1'b1, 1'b1, 4'b1010, 4'b0101, 3'b001);
    for (int k = 0; k < 4; k++) begin
      wait_ready("alt_timeout");
      check("alt_grant", 32'(req1_ready), 32'(k % 2));
      if (req1_ready) sb.push_back(rsp_t'{1'b1, 4'b0000, 1'b0, 1'b1});
      else            sb.push_back(rsp_t'{1'b0, 4'b0000, 1'b1, 1'b1});
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Response stall with both requesters waiting; req1 must win afterwards
    rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 4'b0110, 4'b0011, 3'b000);
    @(negedge clk);
    check("stall_req0_ready", 32'(req0_ready), 32'(1));
    sb.push_back(rsp_t'{1'b0, 4'b1001, 1'b0, 1'b0});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'b0001, 4'b0001, 3'b000);
    drive(1'b1, 1'b1, 4'b0010, 4'b0010, 3'b001);
    @(negedge clk);
    @(negedge clk);
    snap = {rsp_id, rsp_y, rsp_carry, rsp_zero};
    check("stall_first", 32'(snap), 32'(7'b0_1001_0_0));
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'(1));
      check("stall_hold", 32'({rsp_id, rsp_y, rsp_carry, rsp_zero}), 32'(snap));
      check("stall_readies", 32'({req0_ready, req1_ready}), 32'(0));
      check("stall_busy", 32'(busy), 32'(1));
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("no_starve_req1", 32'({req0_ready, req1_ready}), 32'(2'b01));
    sb.push_back(rsp_t'{1'b1, 4'b0010, 1'b0, 1'b0});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_ready("req0_timeout");
    check("req0_after", 32'(req0_ready), 32'(1));
    sb.push_back(rsp_t'{1'b0, 4'b0010, 1'b0, 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drain();

    // HOLD_CYCLES=3 instance: exact latency and stable operands
    h_req0_valid = 1'b1; h_req0_a = 4'b0011; h_req0_b = 4'b0100; h_req0_op = 3'b000;
    @(negedge clk);
    check("h_ready", 32'(h_req0_ready), 32'(1));
    @(posedge clk); #1;
    h_req0_valid = 1'b0; h_req0_a = 4'b1111; h_req0_b = 4'b1111; h_req0_op = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("h_lat_early", 32'(h_rsp_valid), 32'(0));
      check("h_alu_stable", 32'({h_alu_a, h_alu_b, h_alu_s}), 32'({4'b0011, 4'b0100, 3'b000}));
    end
    @(negedge clk);
    check("h_rsp", 32'({h_rsp_valid, h_rsp_id, h_rsp_y, h_rsp_carry, h_rsp_zero}), 32'(8'b1_0_0111_0_0));
    @(posedge clk); #1;
    @(negedge clk);
    check("h_idle", 32'({h_busy, h_rsp_valid}), 32'(0));
    @(posedge clk); #1;

    // Reset mid-EXEC: transaction dropped, rr pointer back to 0
    run_one('{1'b0, 4'b0001, 4'b0010, 3'b000, 4'b0011, 1'b0, 1'b0});
    drain();
    drive(1'b1, 1'b1, 4'b0101, 4'b0101, 3'b000);
    @(negedge clk);
    check("pre_rst_req1", 32'(req1_ready), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); check("no_rsp_after_rst", 32'({rsp_valid, busy}), 32'(0)); end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'b0010, 4'b0001, 3'b000);
    drive(1'b1, 1'b1, 4'b0100, 4'b0100, 3'b000);
    @(negedge clk);
    check("post_rst_rr", 32'({req0_ready, req1_ready}), 32'(2'b10));
    sb.push_back(rsp_t'{1'b0, 4'b0011, 1'b0, 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
